// File: rtl/stmpe610_seq_if.sv
// Start/done handshake between the STMPE610 command sequencer (master) and the
// byte-level SPI master (slave).
interface stmpe610_seq_if;
  logic        spi_start;
  logic [15:0] spi_tx;
  logic        spi_busy;
  logic        spi_done;
  logic [7:0]  spi_rx;

  modport master (output spi_start, spi_tx, input spi_busy, spi_done, spi_rx);
  modport slave  (input spi_start, spi_tx, output spi_busy, spi_done, spi_rx);
endinterface

// File: rtl/stmpe610_seq.sv
// STMPE610 command sequencer: init ROM, chip-ID read, then periodic FIFO_SIZE polling.
// Optional: define STMPE610_SEQ_ID_CHECK_EN to halt with err when the chip ID is not 0x0811.
module stmpe610_seq #(
  parameter int POLL_CYCLES = 1000000,
  parameter int RST_WAIT    = 100000,
  parameter int TIMEOUT     = 4096
) (
  input  logic           SYSCLK,
  input  logic           RSTN,
  input  logic           i_restart,
  stmpe610_seq_if.master spi,
  output logic           o_ready,
  output logic [15:0]    o_chip_id,
  output logic [7:0]     o_fifo_level,
  output logic           o_level_valid,
  output logic           o_err
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELAY, S_POLL, S_HALT} state_t;

  localparam logic [2:0]  STEP_ID_HI = 3'd4;
  localparam logic [2:0]  STEP_ID_LO = 3'd5;
  localparam logic [2:0]  STEP_POLL  = 3'd6;
  localparam logic [31:0] POLL_LAST  = 32'(POLL_CYCLES - 1);
  localparam logic [31:0] WAIT_LAST  = 32'(RST_WAIT - 1);
  localparam logic [31:0] TO_LAST    = 32'(TIMEOUT - 1);
`ifdef STMPE610_SEQ_ID_CHECK_EN
  localparam logic [15:0] CHIP_ID    = 16'h0811;
`endif

  function automatic logic [15:0] wr(input logic [7:0] a, input logic [7:0] d);
    return {a & 8'h7F, d};
  endfunction

  function automatic logic [15:0] rd(input logic [7:0] a);
    return {a | 8'h80, 8'h00};
  endfunction

  // Steps 0..3 are the init writes, 4..5 the ID reads, 6 the FIFO_SIZE poll.
  function automatic logic [15:0] step_tx(input logic [2:0] s);
    case (s)
      3'd0:       step_tx = wr(8'h03, 8'h02);
      3'd1:       step_tx = wr(8'h03, 8'h00);
      3'd2:       step_tx = wr(8'h04, 8'h0C);
      3'd3:       step_tx = wr(8'h40, 8'h01);
      STEP_ID_HI: step_tx = rd(8'h00);
      STEP_ID_LO: step_tx = rd(8'h01);
      default:    step_tx = rd(8'h4C);
    endcase
  endfunction

  state_t      r_state, w_state;
  logic [2:0]  r_step, w_step;
  logic [31:0] r_cnt, w_cnt;
  logic [15:0] r_tx, w_tx;
  logic        r_pend, w_pend;
  logic        r_ready, w_ready;
  logic [15:0] r_chip_id, w_chip_id;
  logic [7:0]  r_level, w_level;
  logic        r_lvl_vld, w_lvl_vld;
  logic        r_err, w_err;
  logic        w_start;
  logic        w_init;

  always_ff @(posedge SYSCLK) begin
    if (!RSTN) begin
      r_state   <= S_IDLE;
      r_step    <= '0;
      r_cnt     <= '0;
      r_tx      <= '0;
      r_pend    <= 1'b0;
      r_ready   <= 1'b0;
      r_chip_id <= '0;
      r_level   <= '0;
      r_lvl_vld <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_step    <= w_step;
      r_cnt     <= w_cnt;
      r_tx      <= w_tx;
      r_pend    <= w_pend;
      r_ready   <= w_ready;
      r_chip_id <= w_chip_id;
      r_level   <= w_level;
      r_lvl_vld <= w_lvl_vld;
      r_err     <= w_err;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_step    = r_step;
    w_cnt     = r_cnt;
    w_tx      = r_tx;
    w_pend    = r_pend;
    w_ready   = r_ready;
    w_chip_id = r_chip_id;
    w_level   = r_level;
    w_lvl_vld = 1'b0;
    w_err     = r_err;
    w_start   = 1'b0;
    w_init    = 1'b0;
    case (r_state)
      S_IDLE: w_init = 1'b1;
      S_ISSUE: begin
        // A restart here still lets the frame go out; it is honoured at spi_done.
        if (i_restart) w_pend = 1'b1;
        if (!spi.spi_busy) begin
          w_start = 1'b1;
          w_state = S_WAIT;
          w_cnt   = 32'd1;
        end
      end
      S_WAIT: begin
        if (i_restart) w_pend = 1'b1;
        if (spi.spi_done) begin
          w_cnt = '0;
          if (r_pend || i_restart) begin
            w_init = 1'b1;
          end else begin
            case (r_step)
              3'd0: begin
                w_state = S_DELAY;
                w_step  = 3'd1;
              end
              STEP_ID_HI: begin
                w_chip_id[15:8] = spi.spi_rx;
                w_step          = STEP_ID_LO;
                w_state         = S_ISSUE;
              end
              STEP_ID_LO: begin
                w_chip_id[7:0] = spi.spi_rx;
`ifdef STMPE610_SEQ_ID_CHECK_EN
                if ({r_chip_id[15:8], spi.spi_rx} != CHIP_ID) begin
                  w_err   = 1'b1;
                  w_state = S_HALT;
                end else begin
                  w_ready = 1'b1;
                  w_step  = STEP_POLL;
                  w_state = S_POLL;
                end
`else
                w_ready = 1'b1;
                w_step  = STEP_POLL;
                w_state = S_POLL;
`endif
              end
              STEP_POLL: begin
                w_level   = spi.spi_rx;
                w_lvl_vld = 1'b1;
                w_state   = S_POLL;
              end
              default: begin
                w_step  = r_step + 3'd1;
                w_state = S_ISSUE;
              end
            endcase
          end
        end else if (r_cnt >= TO_LAST) begin
          w_err   = 1'b1;
          w_ready = 1'b0;
          w_pend  = 1'b0;
          w_state = S_HALT;
        end else begin
          w_cnt = r_cnt + 32'd1;
        end
      end
      S_DELAY: begin
        if (i_restart)               w_init = 1'b1;
        else if (r_cnt == WAIT_LAST) begin
          w_cnt   = '0;
          w_state = S_ISSUE;
        end else                     w_cnt = r_cnt + 32'd1;
      end
      S_POLL: begin
        if (i_restart)               w_init = 1'b1;
        else if (r_cnt == POLL_LAST) begin
          w_cnt   = '0;
          w_state = S_ISSUE;
        end else                     w_cnt = r_cnt + 32'd1;
      end
      S_HALT: if (i_restart) w_init = 1'b1;
      default: w_state = S_IDLE;
    endcase

    if (w_init) begin
      w_state   = S_ISSUE;
      w_step    = '0;
      w_cnt     = '0;
      w_pend    = 1'b0;
      w_err     = 1'b0;
      w_ready   = 1'b0;
      w_chip_id = '0;
    end
    // The frame word is loaded on the way into ISSUE and held through WAIT.
    if (w_state == S_ISSUE) w_tx = step_tx(w_step);
  end

  assign spi.spi_start  = w_start;
  assign spi.spi_tx     = r_tx;
  assign o_ready        = r_ready;
  assign o_chip_id      = r_chip_id;
  assign o_fifo_level   = r_level;
  assign o_level_valid  = r_lvl_vld;
  assign o_err          = r_err;
endmodule

// File: tb/tb_stmpe610_seq.sv
// Scoreboard bench for stmpe610_seq: SPI slave model, expected-frame/level queues,
// monitor that checks every spi_start and level_valid against the queues.
module tb_stmpe610_seq;
  localparam int POLL = 200;
  localparam int RW   = 50;
  localparam int TO   = 64;
  localparam int DLY  = 40;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        restart = 1'b0;
  logic        ready, lvl_vld, err;
  logic [15:0] chip_id;
  logic [7:0]  level;

  stmpe610_seq_if ifc();

  stmpe610_seq #(.POLL_CYCLES(POLL), .RST_WAIT(RW), .TIMEOUT(TO)) dut (
    .SYSCLK(clk), .RSTN(rstn), .i_restart(restart), .spi(ifc),
    .o_ready(ready), .o_chip_id(chip_id), .o_fifo_level(level),
    .o_level_valid(lvl_vld), .o_err(err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] exp_tx[$];
  logic [7:0]  exp_lvl[$];

  // model controls (written by main only)
  bit          hang = 1'b0;
  int          abort_req = 0;
  int          busy_until = 0;
  logic [15:0] mdl_id = 16'h0811;
  logic [7:0]  mdl_lvl = 8'h05;

  // monitor state
  int n_start = 0, n_done = 0, n_lvl = 0;
  int last_done = 0, last_start = 0, last_gap = 0, err_cyc = 0;
  logic err_q = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #3;
  endtask

  function automatic int cur(input int k);
    case (k)
      0: return n_start;
      1: return n_lvl;
      2: return n_done;
      3: return int'(ready);
      default: return int'(err);
    endcase
  endfunction

  task automatic wait_until(input int k, input int target, input int budget, input string nm);
    int w;
    w = 0;
    while (cur(k) < target && w < budget) begin
      tick(1);
      w++;
    end
    chk({nm, "_reached"}, 32'(cur(k) >= target), 32'd1);
  endtask

  task automatic push_init();
    exp_tx.push_back(16'h0302);
    exp_tx.push_back(16'h0300);
    exp_tx.push_back(16'h040C);
    exp_tx.push_back(16'h4001);
    exp_tx.push_back(16'h8000);
    exp_tx.push_back(16'h8100);
  endtask

  // SPI master model: busy from the cycle after start, done DLY cycles after start.
  initial begin
    bit          active;
    int          mcnt;
    int          ack;
    logic [15:0] mtx;
    active = 1'b0; mcnt = 0; ack = 0; mtx = '0;
    ifc.spi_busy = 1'b0; ifc.spi_done = 1'b0; ifc.spi_rx = '0;
    forever begin
      @(negedge clk);
      ifc.spi_done = 1'b0;
      if (!rstn || ack != abort_req) begin
        ack = abort_req;
        active = 1'b0;
        ifc.spi_busy = 1'b0;
      end else if (active) begin
        mcnt++;
        ifc.spi_busy = 1'b1;
        if (!hang && mcnt == DLY) begin
          ifc.spi_done = 1'b1;
          ifc.spi_busy = 1'b0;
          active = 1'b0;
          case (mtx[15:8])
            8'h80:   ifc.spi_rx = mdl_id[15:8];
            8'h81:   ifc.spi_rx = mdl_id[7:0];
            8'hCC:   ifc.spi_rx = mdl_lvl;
            default: ifc.spi_rx = 8'h00;
          endcase
        end
      end else begin
        ifc.spi_busy = (cyc < busy_until);
      end
      #1;
      if (rstn && !active && ifc.spi_start) begin
        active = 1'b1;
        mcnt = 0;
        mtx = ifc.spi_tx;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a frame or a level.
  initial forever begin
    @(negedge clk);
    #2;
    if (rstn) begin
      if (ifc.spi_done) begin
        n_done++;
        last_done = cyc;
      end
      if (ifc.spi_start) begin
        n_start++;
        last_gap = cyc - last_done;
        last_start = cyc;
        chk("start_while_busy", 32'(ifc.spi_busy), 32'd0);
        if (exp_tx.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_start: got tx %0h want none (cycle %0d)", ifc.spi_tx, cyc);
        end else chk("spi_tx", 32'(ifc.spi_tx), 32'(exp_tx.pop_front()));
      end
      if (lvl_vld) begin
        n_lvl++;
        chk("lvl_after_done", 32'(cyc - last_done), 32'd1);
        if (exp_lvl.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_level_valid: got level %0h want none (cycle %0d)", level, cyc);
        end else chk("fifo_level", 32'(level), 32'(exp_lvl.pop_front()));
      end
      if (err && !err_q) err_cyc = cyc;
      err_q = err;
    end else err_q = 1'b0;
  end

  initial begin
    int s0, d0;
    tick(3);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_chip_id", 32'(chip_id), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_lvl_vld", 32'(lvl_vld), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_start", 32'(ifc.spi_start), 32'd0);
    chk("rst_tx", 32'(ifc.spi_tx), 32'd0);

    // init sequence and ID read
    push_init();
    rstn = 1'b1;
    wait_until(0, 2, 300, "second_write");
    chk("soft_reset_gap", 32'(last_gap), 32'(RW + 1));
    wait_until(3, 1, 2000, "ready_init");
    chk("chip_id", 32'(chip_id), 32'h0811);
    chk("err_after_init", 32'(err), 32'd0);

    // two polls
    repeat (2) begin
      exp_tx.push_back(16'hCC00);
      exp_lvl.push_back(8'h05);
    end
    wait_until(1, 2, 1000, "two_polls");
    chk("poll_gap", 32'(last_gap), 32'(POLL + 1));

    // busy held across ISSUE
    busy_until = cyc + 231;
    mdl_lvl = 8'h09;
    exp_tx.push_back(16'hCC00);
    exp_lvl.push_back(8'h09);
    wait_until(0, 9, 600, "busy_poll_start");
    chk("busy_release_gap", 32'(last_gap >= 232 && last_gap <= 233), 32'd1);
    wait_until(1, 3, 200, "busy_poll_level");

    // restart mid poll transfer, with a duplicate pulse
    exp_tx.push_back(16'hCC00);
    push_init();
    wait_until(0, 10, 400, "poll_before_restart");
    tick(10);
    restart = 1'b1; tick(1); restart = 1'b0;
    tick(4);
    restart = 1'b1; tick(1); restart = 1'b0;
    d0 = n_done;
    wait_until(2, d0 + 1, 100, "restart_frame_done");
    tick(2);
    chk("restart_ready_low", 32'(ready), 32'd0);
    chk("restart_chip_id_clr", 32'(chip_id), 32'd0);
    wait_until(0, 11, 50, "restart_first_write");
    chk("restart_gap", 32'(last_gap), 32'd1);
    wait_until(0, 15, 1000, "restart_id_read");
    chk("ready_low_before_id", 32'(ready), 32'd0);
    wait_until(3, 1, 500, "ready_reinit");
    chk("chip_id_reinit", 32'(chip_id), 32'h0811);

    // timeout
    hang = 1'b1;
    exp_tx.push_back(16'hCC00);
    wait_until(0, 17, 400, "hang_poll_start");
    wait_until(4, 1, 200, "timeout_err");
    chk("timeout_latency", 32'(err_cyc - last_start), 32'(TO));
    chk("timeout_ready", 32'(ready), 32'd0);
    s0 = n_start;
    tick(300);
    chk("halt_no_start", 32'(n_start), 32'(s0));

    // restart out of HALT with a wrong chip ID
    hang = 1'b0;
    abort_req++;
    mdl_id = 16'h0812;
    push_init();
    tick(1);
    restart = 1'b1; tick(1); restart = 1'b0;
    tick(1);
    chk("restart_clears_err", 32'(err), 32'd0);
    wait_until(0, 23, 1000, "bad_id_read");
    d0 = n_done;
    wait_until(2, d0 + 1, 100, "bad_id_done");
    tick(2);
    chk("bad_chip_id", 32'(chip_id), 32'h0812);
`ifdef STMPE610_SEQ_ID_CHECK_EN
    chk("id_check_err", 32'(err), 32'd1);
    chk("id_check_ready", 32'(ready), 32'd0);
    s0 = n_start;
    tick(300);
    chk("id_check_no_poll", 32'(n_start), 32'(s0));
`else
    chk("no_id_check_err", 32'(err), 32'd0);
    chk("no_id_check_ready", 32'(ready), 32'd1);
    exp_tx.push_back(16'hCC00);
    wait_until(0, 24, 400, "poll_after_bad_id");
    tick(5);
`endif

    // reset mid-transfer
    rstn = 1'b0;
    tick(2);
    chk("rst2_ready", 32'(ready), 32'd0);
    chk("rst2_chip_id", 32'(chip_id), 32'd0);
    chk("rst2_err", 32'(err), 32'd0);
    chk("rst2_start", 32'(ifc.spi_start), 32'd0);
    chk("rst2_tx", 32'(ifc.spi_tx), 32'd0);
    exp_tx.push_back(16'h0302);
    s0 = n_start;
    rstn = 1'b1;
    wait_until(0, s0 + 1, 50, "post_reset_start");
    chk("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
    chk("lvl_queue_empty", 32'(exp_lvl.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
